primitive_assembler: RTL and testbench

- Consumer of the vertex shader's projected screen-space stream.
- Collects incoming 2D vertices into triangles, computes signed area and a screen-clamped bounding box, and optionally culls back-facing, degenerate or off-screen triangles.
- Emits one setup record per surviving triangle to the rasterizer over a valid/ready handshake.

---
 rtl/primitive_assembler_if.sv | 42 ++++
 rtl/primitive_assembler.sv | 228 ++++++++++++++++++++++
 tb/tb_primitive_assembler.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/primitive_assembler_if.sv
// Vertex-in / triangle-out bundle for the primitive assembler.
// slave = assembler side, master = vertex source / rasterizer side.
interface primitive_assembler_if #(
    parameter int COORD_W = 32
);
    logic                       vtx_valid;
    logic                       vtx_ready;
    logic signed [COORD_W-1:0]  vtx_x;
    logic signed [COORD_W-1:0]  vtx_y;
    logic                       cull_en;
    logic                       tri_valid;
    logic                       tri_ready;
    logic signed [COORD_W-1:0]  tri_x0;
    logic signed [COORD_W-1:0]  tri_y0;
    logic signed [COORD_W-1:0]  tri_x1;
    logic signed [COORD_W-1:0]  tri_y1;
    logic signed [COORD_W-1:0]  tri_x2;
    logic signed [COORD_W-1:0]  tri_y2;
    logic signed [2*COORD_W+2:0] tri_area;
    logic signed [COORD_W-1:0]  bbox_xmin;
    logic signed [COORD_W-1:0]  bbox_xmax;
    logic signed [COORD_W-1:0]  bbox_ymin;
    logic signed [COORD_W-1:0]  bbox_ymax;
    logic [15:0]                tri_count;
    logic [15:0]                cull_count;

    modport slave (
        input  vtx_valid, vtx_x, vtx_y, cull_en, tri_ready,
        output vtx_ready, tri_valid,
        output tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2,
        output tri_area, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
        output tri_count, cull_count
    );

    modport master (
        output vtx_valid, vtx_x, vtx_y, cull_en, tri_ready,
        input  vtx_ready, tri_valid,
        input  tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2,
        input  tri_area, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
        input  tri_count, cull_count
    );
endinterface

// File: rtl/primitive_assembler.sv
// Triangle assembly, signed area, clamped bbox and culling ahead of raster.
// Optional triangle-strip support is enabled with `define PRIM_STRIP_EN.
module primitive_assembler #(
    parameter int COORD_W  = 32,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef PRIM_STRIP_EN
    input  logic                  strip_mode,
`endif
    primitive_assembler_if.slave  bus
);
    localparam int AW = 2*COORD_W+3;
    localparam int PW = 2*COORD_W+2;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef enum logic [1:0] {COLLECT, SETUP, EMIT} state_t;

    localparam coord_t XMAX = coord_t'(SCREEN_W-1);
    localparam coord_t YMAX = coord_t'(SCREEN_H-1);

    state_t r_state;
    state_t w_next;

    coord_t r_vx [3];
    coord_t r_vy [3];
    logic [1:0] r_idx;

    coord_t r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
    coord_t r_xmin, r_xmax, r_ymin, r_ymax;
    logic signed [AW-1:0] r_area;
    logic [15:0] r_tri_cnt;
    logic [15:0] r_cull_cnt;

    logic w_vtx_fire;
    logic w_tri_fire;
    logic w_resolve;
    logic w_swap;
    logic w_cull;

    coord_t w_ax, w_ay, w_bx, w_by, w_cx, w_cy;
    coord_t w_rxmin, w_rxmax, w_rymin, w_rymax;
    logic signed [COORD_W:0] w_d1x, w_d1y, w_d2x, w_d2y;
    logic signed [PW-1:0] w_p1, w_p2;
    logic signed [AW-1:0] w_area;

    function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic coord_t clamp(coord_t v, coord_t hi);
        if (v[COORD_W-1])
            return '0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    assign w_vtx_fire = bus.vtx_valid && (r_state == COLLECT);
    assign w_tri_fire = bus.tri_ready && (r_state == EMIT);

`ifdef PRIM_STRIP_EN
    logic r_parity;
    assign w_swap = r_parity;
`else
    assign w_swap = 1'b0;
`endif

    // Odd strip triangles swap v0/v1 so every record keeps one winding
    assign w_ax = w_swap ? r_vx[1] : r_vx[0];
    assign w_ay = w_swap ? r_vy[1] : r_vy[0];
    assign w_bx = w_swap ? r_vx[0] : r_vx[1];
    assign w_by = w_swap ? r_vy[0] : r_vy[1];
    assign w_cx = r_vx[2];
    assign w_cy = r_vy[2];

    assign w_d1x = {w_bx[COORD_W-1], w_bx} - {w_ax[COORD_W-1], w_ax};
    assign w_d1y = {w_by[COORD_W-1], w_by} - {w_ay[COORD_W-1], w_ay};
    assign w_d2x = {w_cx[COORD_W-1], w_cx} - {w_ax[COORD_W-1], w_ax};
    assign w_d2y = {w_cy[COORD_W-1], w_cy} - {w_ay[COORD_W-1], w_ay};

    assign w_p1 = PW'(w_d1x) * PW'(w_d2y);
    assign w_p2 = PW'(w_d2x) * PW'(w_d1y);
    assign w_area = {w_p1[PW-1], w_p1} - {w_p2[PW-1], w_p2};

    assign w_rxmin = min3(w_ax, w_bx, w_cx);
    assign w_rxmax = max3(w_ax, w_bx, w_cx);
    assign w_rymin = min3(w_ay, w_by, w_cy);
    assign w_rymax = max3(w_ay, w_by, w_cy);

    assign w_cull = bus.cull_en && (
        w_area[AW-1] || (w_area == '0) ||
        w_rxmax[COORD_W-1] || (w_rxmin > XMAX) ||
        w_rymax[COORD_W-1] || (w_rymin > YMAX));

    always_comb begin
        w_next    = r_state;
        w_resolve = 1'b0;
        unique case (r_state)
            COLLECT: begin
                if (w_vtx_fire && (r_idx == 2'd2))
                    w_next = SETUP;
            end
            SETUP: begin
                if (w_cull) begin
                    w_next    = COLLECT;
                    w_resolve = 1'b1;
                end else begin
                    w_next = EMIT;
                end
            end
            EMIT: begin
                if (w_tri_fire) begin
                    w_next    = COLLECT;
                    w_resolve = 1'b1;
                end
            end
            default: w_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= COLLECT;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
            r_idx <= '0;
`ifdef PRIM_STRIP_EN
            r_parity <= 1'b0;
`endif
        end else if (w_vtx_fire) begin
            r_vx[r_idx] <= bus.vtx_x;
            r_vy[r_idx] <= bus.vtx_y;
            r_idx       <= r_idx + 2'd1;
        end else if (w_resolve) begin
`ifdef PRIM_STRIP_EN
            if (strip_mode) begin
                r_vx[0]  <= r_vx[1];
                r_vy[0]  <= r_vy[1];
                r_vx[1]  <= r_vx[2];
                r_vy[1]  <= r_vy[2];
                r_idx    <= 2'd2;
                r_parity <= ~r_parity;
            end else begin
                r_idx    <= '0;
                r_parity <= 1'b0;
            end
`else
            r_idx <= '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x0   <= '0;
            r_y0   <= '0;
            r_x1   <= '0;
            r_y1   <= '0;
            r_x2   <= '0;
            r_y2   <= '0;
            r_area <= '0;
            r_xmin <= '0;
            r_xmax <= '0;
            r_ymin <= '0;
            r_ymax <= '0;
        end else if ((r_state == SETUP) && !w_cull) begin
            r_x0   <= w_ax;
            r_y0   <= w_ay;
            r_x1   <= w_bx;
            r_y1   <= w_by;
            r_x2   <= w_cx;
            r_y2   <= w_cy;
            r_area <= w_area;
            r_xmin <= clamp(w_rxmin, XMAX);
            r_xmax <= clamp(w_rxmax, XMAX);
            r_ymin <= clamp(w_rymin, YMAX);
            r_ymax <= clamp(w_rymax, YMAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tri_cnt  <= '0;
            r_cull_cnt <= '0;
        end else begin
            if (w_tri_fire)
                r_tri_cnt <= r_tri_cnt + 16'd1;
            if ((r_state == SETUP) && w_cull)
                r_cull_cnt <= r_cull_cnt + 16'd1;
        end
    end

    assign bus.vtx_ready  = (r_state == COLLECT);
    assign bus.tri_valid  = (r_state == EMIT);
    assign bus.tri_x0     = r_x0;
    assign bus.tri_y0     = r_y0;
    assign bus.tri_x1     = r_x1;
    assign bus.tri_y1     = r_y1;
    assign bus.tri_x2     = r_x2;
    assign bus.tri_y2     = r_y2;
    assign bus.tri_area   = r_area;
    assign bus.bbox_xmin  = r_xmin;
    assign bus.bbox_xmax  = r_xmax;
    assign bus.bbox_ymin  = r_ymin;
    assign bus.bbox_ymax  = r_ymax;
    assign bus.tri_count  = r_tri_cnt;
    assign bus.cull_count = r_cull_cnt;
endmodule

// File: tb/tb_primitive_assembler.sv
// Directed bench for primitive_assembler: latency, area, clamp, culling,
// backpressure, mid-stream reset and (with PRIM_STRIP_EN) strip mode.
module tb_primitive_assembler;
    logic clk = 1'b0;
    logic rst_n;
    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    primitive_assembler_if #(.COORD_W(32)) bus();

`ifdef PRIM_STRIP_EN
    logic strip_mode;
`endif

    primitive_assembler #(
        .COORD_W(32), .SCREEN_W(640), .SCREEN_H(480)
    ) dut (
        .clk(clk),
        .reset(rst_n),
`ifdef PRIM_STRIP_EN
        .strip_mode(strip_mode),
`endif
        .bus(bus)
    );

    task automatic send_vtx(input int x, input int y);
        int t;
        t = 0;
        @(negedge clk);
        bus.vtx_valid = 1'b1;
        bus.vtx_x = x;
        bus.vtx_y = y;
        while (!bus.vtx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.vtx_ready) begin
            n_run++; n_fail++;
            $display("FAIL send_vtx: vtx_ready=0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        bus.vtx_valid = 1'b0;
        bus.vtx_x = 32'h5a5a_1234;
        bus.vtx_y = 32'h7777_0001;
    endtask

    task automatic wait_tri();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.tri_valid && t < 20);
        if (!bus.tri_valid) begin
            n_run++; n_fail++;
            $display("FAIL wait_tri: tri_valid=0 expected 1 within 20 cycles");
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.tri_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.tri_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.vtx_valid = 1'b1;
        bus.vtx_x = 7;
        bus.vtx_y = 9;
        bus.tri_ready = 1'b0;
        bus.cull_en = 1'b0;
        repeat (3) @(negedge clk);
        n_run++;
        if (bus.vtx_ready !== 1'b1 || bus.tri_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: ready=%b valid=%b expected 1 0",
                     bus.vtx_ready, bus.tri_valid);
        end
        n_run++;
        if ({bus.tri_x0, bus.tri_y0, bus.tri_x1, bus.tri_y1, bus.tri_x2,
             bus.tri_y2, bus.tri_area} !== '0) begin
            n_fail++;
            $display("FAIL reset_tri: area=%0d x0=%0d expected 0 0",
                     bus.tri_area, bus.tri_x0);
        end
        n_run++;
        if ({bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax,
             bus.tri_count, bus.cull_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_bbox_cnt: xmax=%0d tri=%0d cull=%0d expected 0",
                     bus.bbox_xmax, bus.tri_count, bus.cull_count);
        end
        bus.vtx_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_run++;
        if (bus.vtx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: vtx_ready=%b expected 1", bus.vtx_ready);
        end
    endtask

    task automatic test_front();
        bus.cull_en = 1'b1;
        send_vtx(0, 0);
        send_vtx(10, 0);
        send_vtx(0, 10);
        @(negedge clk);
        n_run++;
        if (bus.tri_valid !== 1'b0 || bus.vtx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL front_setup: valid=%b ready=%b expected 0 0",
                     bus.tri_valid, bus.vtx_ready);
        end
        @(negedge clk);
        n_run++;
        if (bus.tri_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL front_latency: tri_valid=%b expected 1", bus.tri_valid);
        end
        n_run++;
        if (bus.tri_area !== 67'sd100) begin
            n_fail++;
            $display("FAIL front_area: got %0d expected 100", bus.tri_area);
        end
        n_run++;
        if ({bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax} !==
            {32'sd0, 32'sd10, 32'sd0, 32'sd10}) begin
            n_fail++;
            $display("FAIL front_bbox: got %0d..%0d/%0d..%0d expected 0..10/0..10",
                     bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax);
        end
        n_run++;
        if ({bus.tri_x0, bus.tri_y0, bus.tri_x1, bus.tri_y1, bus.tri_x2, bus.tri_y2} !==
            {32'sd0, 32'sd0, 32'sd10, 32'sd0, 32'sd0, 32'sd10}) begin
            n_fail++;
            $display("FAIL front_verts: got (%0d,%0d)(%0d,%0d)(%0d,%0d) expected (0,0)(10,0)(0,10)",
                     bus.tri_x0, bus.tri_y0, bus.tri_x1, bus.tri_y1, bus.tri_x2, bus.tri_y2);
        end
        handshake();
        n_run++;
        if (bus.tri_valid !== 1'b0 || bus.vtx_ready !== 1'b1 || bus.tri_count !== 16'd1) begin
            n_fail++;
            $display("FAIL front_hs: valid=%b ready=%b count=%0d expected 0 1 1",
                     bus.tri_valid, bus.vtx_ready, bus.tri_count);
        end
    endtask

    task automatic test_reversed();
        bus.cull_en = 1'b1;
        send_vtx(0, 0);
        send_vtx(0, 10);
        send_vtx(10, 0);
        @(negedge clk);
        n_run++;
        if (bus.vtx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rev_setup: vtx_ready=%b expected 0", bus.vtx_ready);
        end
        @(negedge clk);
        n_run++;
        if (bus.tri_valid !== 1'b0 || bus.vtx_ready !== 1'b1 || bus.cull_count !== 16'd1) begin
            n_fail++;
            $display("FAIL rev_cull: valid=%b ready=%b cull=%0d expected 0 1 1",
                     bus.tri_valid, bus.vtx_ready, bus.cull_count);
        end
        n_run++;
        if (bus.tri_area !== 67'sd100) begin
            n_fail++;
            $display("FAIL rev_held: area=%0d expected 100", bus.tri_area);
        end
        bus.cull_en = 1'b0;
        send_vtx(0, 0);
        send_vtx(0, 10);
        send_vtx(10, 0);
        wait_tri();
        n_run++;
        if (bus.tri_area !== -67'sd100) begin
            n_fail++;
            $display("FAIL rev_area: got %0d expected -100", bus.tri_area);
        end
        handshake();
        n_run++;
        if (bus.tri_count !== 16'd2 || bus.cull_count !== 16'd1) begin
            n_fail++;
            $display("FAIL rev_counts: tri=%0d cull=%0d expected 2 1",
                     bus.tri_count, bus.cull_count);
        end
    endtask

    task automatic test_clamp();
        bus.cull_en = 1'b1;
        send_vtx(-20, -5);
        send_vtx(700, 10);
        send_vtx(100, 500);
        wait_tri();
        n_run++;
        if (bus.tri_area !== 67'sd361800) begin
            n_fail++;
            $display("FAIL clamp_area: got %0d expected 361800", bus.tri_area);
        end
        n_run++;
        if ({bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax} !==
            {32'sd0, 32'sd639, 32'sd0, 32'sd479}) begin
            n_fail++;
            $display("FAIL clamp_bbox: got %0d..%0d/%0d..%0d expected 0..639/0..479",
                     bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax);
        end
        handshake();
        n_run++;
        if (bus.tri_count !== 16'd3) begin
            n_fail++;
            $display("FAIL clamp_count: got %0d expected 3", bus.tri_count);
        end
        send_vtx(700, 0);
        send_vtx(710, 0);
        send_vtx(700, 10);
        @(negedge clk);
        @(negedge clk);
        n_run++;
        if (bus.tri_valid !== 1'b0 || bus.cull_count !== 16'd2) begin
            n_fail++;
            $display("FAIL offscreen_cull: valid=%b cull=%0d expected 0 2",
                     bus.tri_valid, bus.cull_count);
        end
        n_run++;
        if (bus.tri_x0 !== -32'sd20 || bus.bbox_xmax !== 32'sd639) begin
            n_fail++;
            $display("FAIL offscreen_held: x0=%0d xmax=%0d expected -20 639",
                     bus.tri_x0, bus.bbox_xmax);
        end
    endtask

    task automatic test_backpressure();
        bus.cull_en = 1'b1;
        send_vtx(1, 1);
        send_vtx(5, 1);
        send_vtx(1, 5);
        wait_tri();
        bus.vtx_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.vtx_x = 32'(c * 1000);
            n_run++;
            if (bus.tri_valid !== 1'b1 || bus.vtx_ready !== 1'b0 ||
                bus.tri_area !== 67'sd16 ||
                {bus.tri_x0, bus.tri_y0, bus.tri_x1, bus.tri_y1, bus.tri_x2, bus.tri_y2} !==
                {32'sd1, 32'sd1, 32'sd5, 32'sd1, 32'sd1, 32'sd5} ||
                {bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax} !==
                {32'sd1, 32'sd5, 32'sd1, 32'sd5}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b area=%0d x1=%0d expected 1 0 16 5",
                         c, bus.tri_valid, bus.vtx_ready, bus.tri_area, bus.tri_x1);
            end
        end
        bus.vtx_valid = 1'b0;
        handshake();
        n_run++;
        if (bus.tri_count !== 16'd4 || bus.tri_area !== 67'sd16 || bus.tri_x1 !== 32'sd5) begin
            n_fail++;
            $display("FAIL bp_after: count=%0d area=%0d x1=%0d expected 4 16 5",
                     bus.tri_count, bus.tri_area, bus.tri_x1);
        end
    endtask

    task automatic test_reset_mid();
        bus.cull_en = 1'b1;
        send_vtx(100, 100);
        send_vtx(200, 100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_run++;
        if (bus.vtx_ready !== 1'b1 || bus.tri_count !== 16'd0 ||
            bus.cull_count !== 16'd0 || bus.tri_area !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: ready=%b tri=%0d cull=%0d area=%0d expected 1 0 0 0",
                     bus.vtx_ready, bus.tri_count, bus.cull_count, bus.tri_area);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_vtx(0, 0);
        send_vtx(20, 0);
        send_vtx(0, 20);
        wait_tri();
        n_run++;
        if (bus.tri_area !== 67'sd400 ||
            {bus.tri_x0, bus.tri_y0, bus.tri_x1, bus.tri_y1, bus.tri_x2, bus.tri_y2} !==
            {32'sd0, 32'sd0, 32'sd20, 32'sd0, 32'sd0, 32'sd20}) begin
            n_fail++;
            $display("FAIL mid_fresh: area=%0d x0=%0d x1=%0d expected 400 0 20",
                     bus.tri_area, bus.tri_x0, bus.tri_x1);
        end
        handshake();
        n_run++;
        if (bus.tri_count !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_count: got %0d expected 1", bus.tri_count);
        end
    endtask

`ifdef PRIM_STRIP_EN
    task automatic test_strip();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        strip_mode = 1'b1;
        bus.cull_en = 1'b1;
        send_vtx(0, 0);
        send_vtx(10, 0);
        send_vtx(0, 10);
        wait_tri();
        n_run++;
        if (bus.tri_area !== 67'sd100) begin
            n_fail++;
            $display("FAIL strip_t0: area=%0d expected 100", bus.tri_area);
        end
        handshake();
        send_vtx(10, 10);
        @(negedge clk);
        @(negedge clk);
        n_run++;
        if (bus.tri_valid !== 1'b1 || bus.tri_area !== 67'sd100) begin
            n_fail++;
            $display("FAIL strip_t1: valid=%b area=%0d expected 1 100",
                     bus.tri_valid, bus.tri_area);
        end
        n_run++;
        if ({bus.tri_x0, bus.tri_y0, bus.tri_x1, bus.tri_y1, bus.tri_x2, bus.tri_y2} !==
            {32'sd0, 32'sd10, 32'sd10, 32'sd0, 32'sd10, 32'sd10}) begin
            n_fail++;
            $display("FAIL strip_order: got (%0d,%0d)(%0d,%0d)(%0d,%0d) expected (0,10)(10,0)(10,10)",
                     bus.tri_x0, bus.tri_y0, bus.tri_x1, bus.tri_y1, bus.tri_x2, bus.tri_y2);
        end
        handshake();
        strip_mode = 1'b0;
        n_run++;
        if (bus.tri_count !== 16'd2) begin
            n_fail++;
            $display("FAIL strip_count: got %0d expected 2", bus.tri_count);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef PRIM_STRIP_EN
        strip_mode = 1'b0;
`endif
        bus.vtx_x = '0;
        bus.vtx_y = '0;
        test_reset();
        test_front();
        test_reversed();
        test_clamp();
        test_backpressure();
        test_reset_mid();
`ifdef PRIM_STRIP_EN
        test_strip();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
